// File: rtl/fpu_mant_mul_seq.sv
// rtl/fpu_mant_mul_seq.sv - iterative radix-2 shift-add significand multiplier
//
// Computes the 2*MANT_W product of two significands (hidden bit included)
// over MANT_W cycles. It then normalises the product in one further cycle,
// producing the significand, exponent adjust and guard/sticky bits for the
// exponent/pack stage.
//
// Optional build macro: FPU_MUL_RNE_EN
//   defined   - round-to-nearest-even is applied in NORM
//   undefined - the result is truncated
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-high reset
//   start      operation request, sampled only while idle
//   a_mant     operand A significand (MSB = hidden bit)
//   b_mant     operand B significand (MSB = hidden bit)
//   busy       high while multiplying or normalising
//   done       one-cycle pulse; results are valid from this cycle on
//   prod_mant  normalised product significand (MSB = hidden bit)
//   exp_adj    exponent increment owed by normalisation/rounding
//   guard      first bit below the prod_mant LSB (pre-round)
//   sticky     OR of all bits below guard (pre-round)
//   zero       full product is zero
module fpu_mant_mul_seq #(
  parameter int MANT_W = 8,
  parameter int CNT_W  = $clog2(MANT_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MANT_W-1:0] a_mant,
  input  logic [MANT_W-1:0] b_mant,
  output logic              busy,
  output logic              done,
  output logic [MANT_W-1:0] prod_mant,
  output logic [1:0]        exp_adj,
  output logic              guard,
  output logic              sticky,
  output logic              zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_NORM = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MANT_W - 1);

  state_t              state;
  state_t              state_next;
  logic [2*MANT_W-1:0] mcand;
  logic [MANT_W-1:0]   mplier;
  logic [2*MANT_W-1:0] acc;
  logic [CNT_W-1:0]    cnt;

  logic [MANT_W-1:0]   n_mant;
  logic [1:0]          n_adj;
  logic                n_guard;
  logic                n_sticky;
  logic                n_zero;
`ifdef FPU_MUL_RNE_EN
  logic                round_up;
  logic [MANT_W:0]     rnd;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_MUL;
      S_MUL:   if (cnt == CNT_LAST) state_next = S_NORM;
      S_NORM:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // The normalisation shift is at most one place. Unnormalised operands
  // may leave the hidden-bit position clear; that is passed through as-is.
  always_comb begin
    n_zero = (acc == '0);
    if (acc[2*MANT_W-1]) begin
      n_mant   = acc[2*MANT_W-1:MANT_W];
      n_guard  = acc[MANT_W-1];
      n_sticky = |acc[MANT_W-2:0];
      n_adj    = 2'd1;
    end else begin
      n_mant   = acc[2*MANT_W-2:MANT_W-1];
      n_guard  = acc[MANT_W-2];
      n_sticky = |acc[MANT_W-3:0];
      n_adj    = 2'd0;
    end
`ifdef FPU_MUL_RNE_EN
    round_up = n_guard & (n_sticky | n_mant[0]);
    rnd      = {1'b0, n_mant} + {{MANT_W{1'b0}}, round_up};
    // An all-ones significand rounds up to 1.000.. one binade higher.
    if (rnd[MANT_W]) begin
      n_mant = {1'b1, {(MANT_W-1){1'b0}}};
      n_adj  = n_adj + 2'd1;
    end else begin
      n_mant = rnd[MANT_W-1:0];
    end
`endif
    if (n_zero) begin
      n_mant   = '0;
      n_adj    = 2'd0;
      n_guard  = 1'b0;
      n_sticky = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      prod_mant <= '0;
      exp_adj   <= 2'd0;
      guard     <= 1'b0;
      sticky    <= 1'b0;
      zero      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= {{MANT_W{1'b0}}, a_mant};
            mplier <= b_mant;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        S_MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        S_NORM: begin
          prod_mant <= n_mant;
          exp_adj   <= n_adj;
          guard     <= n_guard;
          sticky    <= n_sticky;
          zero      <= n_zero;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_mant_mul_seq.sv
// tb/tb_fpu_mant_mul_seq.sv - randomized self-checking bench for fpu_mant_mul_seq
module tb_fpu_mant_mul_seq;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a_mant;
  logic [W-1:0] b_mant;
  logic         busy;
  logic         done;
  logic [W-1:0] prod_mant;
  logic [1:0]   exp_adj;
  logic         guard;
  logic         sticky;
  logic         zero;

  int vectors;
  int miscompares;

  fpu_mant_mul_seq #(.MANT_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a_mant    (a_mant),
    .b_mant    (b_mant),
    .busy      (busy),
    .done      (done),
    .prod_mant (prod_mant),
    .exp_adj   (exp_adj),
    .guard     (guard),
    .sticky    (sticky),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product, pick the binade, then optionally round.
  function automatic void model(input int a, input int b,
                                output int pm, output int adj,
                                output int g, output int s, output int z);
    int p;
    p = a * b;
    z = (p == 0) ? 1 : 0;
    if (p >= (1 << (2*W-1))) begin
      pm  = p / (1 << W);
      g   = (p / (1 << (W-1))) % 2;
      s   = ((p % (1 << (W-1))) != 0) ? 1 : 0;
      adj = 1;
    end else begin
      pm  = p / (1 << (W-1));
      g   = (p / (1 << (W-2))) % 2;
      s   = ((p % (1 << (W-2))) != 0) ? 1 : 0;
      adj = 0;
    end
`ifdef FPU_MUL_RNE_EN
    if (g == 1 && (s == 1 || (pm % 2) == 1)) pm = pm + 1;
    if (pm == (1 << W)) begin
      pm  = 1 << (W-1);
      adj = adj + 1;
    end
`endif
    if (z == 1) begin
      pm = 0; adj = 0; g = 0; s = 0;
    end
  endfunction

  // Called at a negedge: presents the operands, lets edge N accept them and
  // returns at the first negedge after edge N with scrambled operand ports.
  task automatic start_op(input int a, input int b);
    start  = 1'b1;
    a_mant = W'(a);
    b_mant = W'(b);
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    a_mant = W'($urandom);
    b_mant = W'($urandom);
  endtask

  // k0 is the number of negedges already elapsed since edge N.
  task automatic wait_done(input int k0, input int a, input int b);
    int k;
    int busy_bad;
    int pm, adj, g, s, z;
    k = k0;
    busy_bad = 0;
    while (!done && k < 40) begin
      if (!busy) busy_bad = 1;
      @(negedge clk);
      k++;
    end
    model(a, b, pm, adj, g, s, z);
    check("busy_during_op", busy_bad, 0);
    check("latency", k, 10);
    check("busy_in_done", busy, 0);
    check("prod_mant", prod_mant, pm);
    check("exp_adj", exp_adj, adj);
    check("guard", guard, g);
    check("sticky", sticky, s);
    check("zero", zero, z);
  endtask

  task automatic run_op(input int a, input int b);
    start_op(a, b);
    wait_done(1, a, b);
    @(negedge clk);
    check("done_pulse_width", done, 0);
  endtask

  initial begin
    int ra, rb, pa, pb;
    int bad;
    vectors     = 0;
    miscompares = 0;
    reset  = 1'b1;
    start  = 1'b0;
    a_mant = '0;
    b_mant = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, prod_mant, exp_adj, guard, sticky, zero}, 0);
    reset = 1'b0;
    @(negedge clk);

    run_op(8'h80, 8'h80);
    run_op(8'hC0, 8'hC0);
    run_op(8'hC1, 8'hC1);
    run_op(8'h81, 8'hC0);
    run_op(8'h00, 8'hFF);
    run_op(8'hFF, 8'hFF);
    run_op(8'hFF, 8'h81);
    run_op(8'h01, 8'h01);

    // A second start three cycles into MUL must be ignored.
    start_op(8'hC1, 8'hC1);
    @(negedge clk);
    @(negedge clk);
    start  = 1'b1;
    a_mant = 8'h80;
    b_mant = 8'h80;
    @(negedge clk);
    start  = 1'b0;
    wait_done(4, 8'hC1, 8'hC1);
    @(negedge clk);
    check("ignored_start_no_second_op", busy, 0);

    // Reset five cycles into MUL aborts immediately with no done.
    start_op(8'hA5, 8'h9C);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_outputs", {busy, done, prod_mant, exp_adj, guard, sticky, zero}, 0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) bad = 1;
    end
    check("abort_no_done", bad, 0);

    // Back-to-back: start during the done cycle.
    start_op(8'hC1, 8'hC1);
    wait_done(1, 8'hC1, 8'hC1);
    start_op(8'h81, 8'hC0);
    wait_done(1, 8'h81, 8'hC0);
    @(negedge clk);
    check("done_pulse_width_b2b", done, 0);

    // Randomized operations, mixing normalised and arbitrary operands and
    // idle gaps with back-to-back starts.
    pa = 8'h80;
    pb = 8'h80;
    start_op(pa, pb);
    for (int i = 0; i < 40; i++) begin
      wait_done(1, pa, pb);
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) begin
        ra = ra | 8'h80;
        rb = rb | 8'h80;
      end
      if ($urandom_range(0, 1) == 0) begin
        @(negedge clk);
        check("rand_done_pulse_width", done, 0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      pa = ra;
      pb = rb;
      start_op(pa, pb);
    end
    wait_done(1, pa, pb);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
